// File: rtl/adc_capture.sv
// ADC acquisition front-end: divided sample clock, level/edge trigger, decimated
// capture of DEPTH samples into a block RAM with a registered read port.
module adc_capture #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4,
    parameter int DEPTH   = 1024,
    parameter int ADDR_W  = 10
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [DATA_W-1:0] ADC_D,
    output logic              ADC_CLK,
    output logic              ADC_nOE,
    input  logic              ARM,
    input  logic [1:0]        TRIG_MODE,
    input  logic [DATA_W-1:0] TRIG_LEVEL,
    input  logic [7:0]        DECIM,
    output logic              BUSY,
    output logic              DONE,
    input  logic [ADDR_W-1:0] RD_ADDR,
    output logic [DATA_W-1:0] RD_DATA
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0]  DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_CAP, S_DONE} state_t;

    state_t            state;
    logic [DIV_W-1:0]  div_cnt;
    logic              s_valid;
    logic [DATA_W-1:0] sample_r;
    logic [DATA_W-1:0] prev;
    logic              prev_ok;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        dec_cnt;
    logic              rise, fall, hit, we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] mem [DEPTH];

    // Free-running divider; never touched by ARM so the ADC clock stays continuous.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            div_cnt  <= '0;
            ADC_CLK  <= 1'b0;
            ADC_nOE  <= 1'b1;
            s_valid  <= 1'b0;
            sample_r <= '0;
        end else begin
            ADC_nOE <= 1'b0;
            ADC_CLK <= (div_cnt < DIV_HALF);
            s_valid <= (div_cnt == DIV_LAST);
            if (div_cnt == DIV_LAST) begin
                sample_r <= ADC_D;
                div_cnt  <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        rise = prev_ok && (prev < TRIG_LEVEL) && (sample_r >= TRIG_LEVEL);
        fall = prev_ok && (prev >= TRIG_LEVEL) && (sample_r < TRIG_LEVEL);
        case (TRIG_MODE)
            2'b00:   hit = 1'b1;
            2'b01:   hit = rise;
            2'b10:   hit = fall;
            default: hit = rise | fall;
        endcase
        // ARM takes priority over any write in the same cycle
        we = s_valid && !ARM &&
             (((state == S_WAIT) && hit) || ((state == S_CAP) && (dec_cnt == DECIM)));
        waddr = (state == S_WAIT) ? '0 : wr_addr;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= S_IDLE;
            wr_addr <= '0;
            dec_cnt <= '0;
            prev    <= '0;
            prev_ok <= 1'b0;
            BUSY    <= 1'b0;
            DONE    <= 1'b0;
        end else begin
            if (s_valid) begin
                prev    <= sample_r;
                prev_ok <= 1'b1;
            end
            if (ARM) begin
                prev_ok <= 1'b0;
                wr_addr <= '0;
                dec_cnt <= '0;
                state   <= S_WAIT;
                BUSY    <= 1'b1;
                DONE    <= 1'b0;
            end else if (s_valid) begin
                case (state)
                    S_WAIT: if (hit) begin
                        wr_addr <= ADDR_W'(1);
                        dec_cnt <= '0;
                        state   <= S_CAP;
                    end
                    S_CAP: if (dec_cnt == DECIM) begin
                        dec_cnt <= '0;
                        wr_addr <= wr_addr + 1'b1;
                        if (wr_addr == LAST) begin
                            state <= S_DONE;
                            BUSY  <= 1'b0;
                            DONE  <= 1'b1;
                        end
                    end else begin
                        dec_cnt <= dec_cnt + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Buffer contents are deliberately not reset so this maps onto block RAM.
    always_ff @(posedge CLK) begin
        if (we) mem[waddr] <= sample_r;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) RD_DATA <= '0;
        else     RD_DATA <= mem[RD_ADDR];
    end
endmodule

// File: tb/tb_adc_capture.sv
// Bench for adc_capture: drives ADC samples one ADC period at a time and checks
// status and buffer contents against a sample-stream model of the trigger rules.
module tb_adc_capture;
    localparam int DEPTH = 16;
    localparam int CLK_DIV = 4;

    logic       CLK = 1'b0;
    logic       RST, ARM;
    logic [7:0] ADC_D, TRIG_LEVEL, DECIM, RD_DATA;
    logic [1:0] TRIG_MODE;
    logic [3:0] RD_ADDR;
    logic       ADC_CLK, ADC_nOE, BUSY, DONE;

    int total = 0;
    int bad = 0;
    int ph;
    logic [7:0] stream[$];
    bit   armed;
    int   m_mode, m_level, m_decim;
    logic [7:0] rd_buf [DEPTH];

    adc_capture #(.DATA_W(8), .CLK_DIV(CLK_DIV), .DEPTH(DEPTH), .ADDR_W(4)) dut (
        .CLK(CLK), .RST(RST), .ADC_D(ADC_D), .ADC_CLK(ADC_CLK), .ADC_nOE(ADC_nOE),
        .ARM(ARM), .TRIG_MODE(TRIG_MODE), .TRIG_LEVEL(TRIG_LEVEL), .DECIM(DECIM),
        .BUSY(BUSY), .DONE(DONE), .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA));

    always #5 CLK = ~CLK;

    // Divider phase as the bench expects it: cycles since reset, modulo CLK_DIV.
    always @(posedge CLK or posedge RST) begin
        if (RST) ph <= 0;
        else     ph <= (ph + 1) % CLK_DIV;
    end

    // ---------------- reference model over the post-ARM sample stream ----------------
    function automatic int trig_idx(int n);
        for (int i = 0; i < n; i++) begin
            bit r, f;
            if (m_mode == 0) return 0;
            if (i == 0) continue;
            r = (stream[i-1] <  m_level) && (stream[i] >= m_level);
            f = (stream[i-1] >= m_level) && (stream[i] <  m_level);
            if ((m_mode == 1 && r) || (m_mode == 2 && f) || (m_mode == 3 && (r || f)))
                return i;
        end
        return -1;
    endfunction

    function automatic bit cap_done(int n);
        int t;
        t = trig_idx(n);
        return armed && (t >= 0) && (t + (DEPTH - 1) * (m_decim + 1) < n);
    endfunction

    // {BUSY, DONE} expected once the newest sample is presented but not yet processed
    function automatic logic [1:0] exp_status();
        bit d;
        if (!armed) return 2'b00;
        d = cap_done(stream.size() - 1);
        return {!d, d};
    endfunction

    function automatic logic [7:0] exp_buf(int j);
        return stream[trig_idx(stream.size()) + j * (m_decim + 1)];
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic cfg(input int mode, input int level, input int decim);
        m_mode = mode; m_level = level; m_decim = decim;
        TRIG_MODE = 2'(mode); TRIG_LEVEL = 8'(level); DECIM = 8'(decim);
    endtask

    // Entered and left at the negedge of a div_cnt==0 cycle. arm_kind: 0 none,
    // 1 ARM mid-period, 2 ARM in the s_valid cycle of the previous sample.
    task automatic feed(input logic [7:0] v, input int arm_kind);
        ADC_D = v;
        if (arm_kind == 2) ARM = 1'b1;
        @(negedge CLK);
        ARM = (arm_kind == 1);
        @(negedge CLK);
        ARM = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        if (arm_kind != 0) begin
            stream.delete();
            armed = 1'b1;
        end
        stream.push_back(v);
    endtask

    task automatic read_all();
        @(negedge CLK);
        RD_ADDR = 4'd0;
        @(negedge CLK);
        for (int a = 1; a <= DEPTH; a++) begin
            rd_buf[a-1] = RD_DATA;
            if (a < DEPTH) RD_ADDR = 4'(a);
            @(negedge CLK);
        end
        while (ph != 0) @(negedge CLK);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [3:0] pat;
        pat = 4'b1100;
        RST = 1'b1; ARM = 1'b0; ADC_D = 8'h00; RD_ADDR = 4'd0;
        cfg(0, 0, 0);
        repeat (3) @(negedge CLK);
        total++;
        if ({ADC_CLK, ADC_nOE, BUSY, DONE, RD_DATA} !== {4'b0100, 8'h00}) begin
            bad++;
            $display("FAIL reset_values: got clk/noe/busy/done/rd=%b want 0100_00000000",
                     {ADC_CLK, ADC_nOE, BUSY, DONE, RD_DATA});
        end
        RST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            total++;
            if (ADC_CLK !== pat[3-i]) begin
                bad++;
                $display("FAIL adc_clk_seq[%0d]: got %b want %b", i, ADC_CLK, pat[3-i]);
            end
            if (i == 0) begin
                total++;
                if (ADC_nOE !== 1'b0) begin
                    bad++;
                    $display("FAIL noe_release: got %b want 0", ADC_nOE);
                end
            end
        end
    endtask

    task automatic test_immediate();
        cfg(0, 0, 0);
        feed(8'h10, 1);
        for (int v = 'h11; v <= 'h20; v++) begin
            feed(8'(v), 0);
            total++;
            if ({BUSY, DONE} !== exp_status()) begin
                bad++;
                $display("FAIL imm_status v=%0h: got %b want %b", v, {BUSY, DONE}, exp_status());
            end
        end
        total++;
        if (DONE !== 1'b1) begin
            bad++;
            $display("FAIL imm_done_after_16: got %b want 1", DONE);
        end
        read_all();
        for (int a = 0; a < DEPTH; a++) begin
            total++;
            if (rd_buf[a] !== exp_buf(a)) begin
                bad++;
                $display("FAIL imm_buf[%0d]: got %h want %h", a, rd_buf[a], exp_buf(a));
            end
        end
    endtask

    task automatic test_rising();
        logic [7:0] v;
        cfg(1, 'h80, 0);
        feed(8'h70, 1);
        feed(8'h7F, 0);
        v = 8'h80;
        for (int k = 0; k < 40 && !cap_done(stream.size()); k++) begin
            feed(v, 0);
            v++;
            total++;
            if ({BUSY, DONE} !== exp_status()) begin
                bad++;
                $display("FAIL rise_status k=%0d: got %b want %b", k, {BUSY, DONE}, exp_status());
            end
        end
        read_all();
        total++;
        if ({rd_buf[0], rd_buf[1], DONE} !== {8'h80, 8'h81, 1'b1}) begin
            bad++;
            $display("FAIL rise_first_two: got %h %h done=%b want 80 81 done=1",
                     rd_buf[0], rd_buf[1], DONE);
        end
        for (int a = 0; a < DEPTH; a++) begin
            total++;
            if (rd_buf[a] !== exp_buf(a)) begin
                bad++;
                $display("FAIL rise_buf[%0d]: got %h want %h", a, rd_buf[a], exp_buf(a));
            end
        end
        // Constant input above the level is never an edge.
        feed(8'h90, 1);
        for (int k = 0; k < 20; k++) begin
            feed(8'h90, 0);
            total++;
            if ({BUSY, DONE} !== 2'b10) begin
                bad++;
                $display("FAIL rise_const k=%0d: got %b want 10", k, {BUSY, DONE});
            end
        end
    endtask

    task automatic test_falling();
        logic [7:0] v;
        cfg(2, 'h80, 0);
        feed(8'h78, 1);
        for (int x = 'h79; x <= 'h88; x++) begin
            feed(8'(x), 0);
            total++;
            if ({BUSY, DONE} !== 2'b10) begin
                bad++;
                $display("FAIL fall_no_trig v=%0h: got %b want 10", x, {BUSY, DONE});
            end
        end
        feed(8'h81, 0);
        v = 8'h7F;
        for (int k = 0; k < 40 && !cap_done(stream.size()); k++) begin
            feed(v, 0);
            v--;
            total++;
            if ({BUSY, DONE} !== exp_status()) begin
                bad++;
                $display("FAIL fall_status k=%0d: got %b want %b", k, {BUSY, DONE}, exp_status());
            end
        end
        read_all();
        total++;
        if ({rd_buf[0], DONE} !== {8'h7F, 1'b1}) begin
            bad++;
            $display("FAIL fall_addr0: got %h done=%b want 7f done=1", rd_buf[0], DONE);
        end
    endtask

    task automatic test_decim();
        cfg(0, 0, 2);
        feed(8'h00, 1);
        for (int k = 1; k <= 3 * DEPTH - 2; k++) begin
            feed(8'(k), 0);
            total++;
            if ({BUSY, DONE} !== exp_status()) begin
                bad++;
                $display("FAIL decim_status k=%0d: got %b want %b", k, {BUSY, DONE}, exp_status());
            end
        end
        total++;
        if (DONE !== 1'b1) begin
            bad++;
            $display("FAIL decim_done: got %b want 1", DONE);
        end
        read_all();
        for (int a = 0; a < DEPTH; a++) begin
            total++;
            if (rd_buf[a] !== 8'(3 * a)) begin
                bad++;
                $display("FAIL decim_buf[%0d]: got %h want %h", a, rd_buf[a], 8'(3 * a));
            end
        end
    endtask

    task automatic test_rearm();
        cfg(0, 0, 0);
        feed(8'h40, 1);
        for (int v = 'h41; v <= 'h44; v++) feed(8'(v), 0);
        // Fifth sample is written as this feed starts, then ARM aborts at wr_addr 5.
        feed(8'hA0, 1);
        for (int v = 'hA1; v <= 'hB0; v++) begin
            feed(8'(v), 0);
            total++;
            if ({BUSY, DONE} !== exp_status()) begin
                bad++;
                $display("FAIL rearm_status v=%0h: got %b want %b", v, {BUSY, DONE}, exp_status());
            end
        end
        read_all();
        for (int a = 0; a < DEPTH; a++) begin
            total++;
            if (rd_buf[a] !== 8'(8'hA0 + a)) begin
                bad++;
                $display("FAIL rearm_buf[%0d]: got %h want %h", a, rd_buf[a], 8'(8'hA0 + a));
            end
        end
        // ARM in the same cycle as the final write.
        feed(8'h20, 1);
        for (int v = 'h21; v <= 'h2F; v++) feed(8'(v), 0);
        feed(8'h55, 2);
        total++;
        if ({BUSY, DONE} !== 2'b10) begin
            bad++;
            $display("FAIL arm_vs_final: got %b want 10", {BUSY, DONE});
        end
        feed(8'h56, 0);
        total++;
        if ({BUSY, DONE} !== exp_status()) begin
            bad++;
            $display("FAIL arm_vs_final_next: got %b want %b", {BUSY, DONE}, exp_status());
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            cfg(int'($urandom_range(0, 3)), int'($urandom_range(8'h40, 8'hC0)),
                int'($urandom_range(0, 2)));
            feed(8'($urandom_range(0, 255)), 1);
            for (int k = 0; k < 120 && !cap_done(stream.size()); k++) begin
                feed(8'($urandom_range(0, 255)), 0);
                total++;
                if ({BUSY, DONE} !== exp_status()) begin
                    bad++;
                    $display("FAIL rand%0d_status k=%0d: got %b want %b",
                             it, k, {BUSY, DONE}, exp_status());
                end
            end
            if (cap_done(stream.size())) begin
                read_all();
                for (int a = 0; a < DEPTH; a++) begin
                    total++;
                    if (rd_buf[a] !== exp_buf(a)) begin
                        bad++;
                        $display("FAIL rand%0d_buf[%0d]: got %h want %h",
                                 it, a, rd_buf[a], exp_buf(a));
                    end
                end
            end
        end
    endtask

    task automatic test_async_reset();
        cfg(1, 'h80, 0);
        feed(8'h10, 1);
        @(posedge CLK);
        #3 RST = 1'b1;
        #1;
        total++;
        if ({ADC_CLK, ADC_nOE, BUSY, DONE, RD_DATA} !== {4'b0100, 8'h00}) begin
            bad++;
            $display("FAIL async_reset: got clk/noe/busy/done/rd=%b want 0100_00000000",
                     {ADC_CLK, ADC_nOE, BUSY, DONE, RD_DATA});
        end
        @(negedge CLK);
        RST = 1'b0;
        armed = 1'b0;
        stream.delete();
        feed(8'h20, 0);
        total++;
        if ({BUSY, DONE, ADC_nOE} !== 3'b000) begin
            bad++;
            $display("FAIL post_reset_idle: got busy/done/noe=%b want 000", {BUSY, DONE, ADC_nOE});
        end
    endtask

    initial begin
        armed = 1'b0;
        test_reset();
        test_immediate();
        test_rising();
        test_falling();
        test_decim();
        test_rearm();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/adc_capture.md
# adc_capture

Parametrised ADC acquisition front-end for the scope. It generates the ADC sample clock from CLK by an integer divider and registers each ADC sample. A level/edge trigger starts the capture of DEPTH samples, with optional decimation, into an internal buffer. The buffer is read back through a synchronous read port by the display/readout logic.

## Interface
Parameters:
- DATA_W, 8: ADC sample width.
- CLK_DIV, 4: ADC_CLK period in CLK cycles. Must be even and ≥ 2.
- DEPTH, 1024: capture buffer depth in samples. Must be a power of two.
- ADDR_W, 10: buffer address width, equal to log2(DEPTH).

Ports:
- CLK  in  1: system clock (100 MHz).
- RST  in  1: reset. One clock; reset is asynchronous and active-high.
- ADC_D  in  DATA_W: ADC parallel data.
- ADC_CLK  out  1: ADC sample clock.
- ADC_nOE  out  1: ADC output enable, active low.
- ARM  in  1: one-cycle pulse that starts or restarts an acquisition.
- TRIG_MODE  in  2: trigger mode.
  - 00: immediate.
  - 01: rising edge.
  - 10: falling edge.
  - 11: either edge.
- TRIG_LEVEL  in  DATA_W: trigger threshold, unsigned.
- DECIM  in  8: store 1 of every DECIM+1 samples. 0 means no decimation.
- BUSY  out  1: high in WAIT_TRIG and CAPTURE.
- DONE  out  1: high in DONE state.
- RD_ADDR  in  ADDR_W: buffer read address.
- RD_DATA  out  DATA_W: buffer read data.

## Operation
Clock divider:
- div_cnt counts 0..CLK_DIV-1 and wraps.
- ADC_CLK is registered: 1 while div_cnt < CLK_DIV/2, else 0.
- In the cycle where div_cnt == CLK_DIV-1, ADC_D is latched into sample_r and s_valid pulses for one cycle.
- One s_valid occurs every CLK_DIV cycles.

ADC_nOE is 1 in reset and 0 from the first CLK edge after RST deasserts.

Trigger detection:
- Uses the current s_valid sample (cur) and the previous s_valid sample (prev). prev_ok is cleared on ARM.
- Rising: prev_ok && prev < TRIG_LEVEL && cur ≥ TRIG_LEVEL.
- Falling: prev_ok && prev ≥ TRIG_LEVEL && cur < TRIG_LEVEL.
- Either: rising OR falling.
- Immediate: any s_valid.

State machine:
- IDLE: wait for ARM.
- WAIT_TRIG: on a trigger hit, write cur to address 0, set wr_addr=1, set dec_cnt=0, go to CAPTURE.
- CAPTURE, on each s_valid:
  - If dec_cnt == DECIM: write cur at wr_addr, increment wr_addr, set dec_cnt=0.
  - Else: increment dec_cnt.
  - After the write to address DEPTH-1, go to DONE.
- DONE: hold buffer contents, wait for ARM.
- ARM in any state clears prev_ok, wr_addr and dec_cnt, and goes to WAIT_TRIG. This includes aborting a CAPTURE in progress.
- DECIM and TRIG_* are sampled live. Changes mid-capture take effect at the next s_valid.

Buffer:
- Single write port and a synchronous read port, inferred as block RAM.
- RD_DATA is registered.
- A simultaneous read and write to the same address returns the old data (read-first).
- Contents are not reset. Locations not yet written read undefined.

## Timing
Reset values:
- ADC_CLK=0, ADC_nOE=1, BUSY=0, DONE=0, RD_DATA=0.
- State=IDLE, div_cnt=0, wr_addr=0.

Divider and sampling:
- The divider runs freely in every state and is not reset by ARM.
- sample_r is updated in the div_cnt==CLK_DIV-1 cycle.
- s_valid is high the following cycle, when div_cnt==0.

Trigger and write:
- The trigger compare and the RAM write occur in the s_valid cycle, so sample-to-write latency is 1 cycle after the latch.
- Edge triggers need at least 2 s_valid pulses after ARM. Immediate mode fires on the first.

State timing:
- BUSY rises the cycle after ARM.
- DONE rises and BUSY falls the cycle after the final write.
- DONE stays high until the cycle after the next ARM.
- ARM in the same cycle as a final write: ARM wins. The state goes to WAIT_TRIG and DONE never asserts.

Address, decimation and readout:
- wr_addr is ADDR_W bits and never wraps within one capture.
- Decimation period is (DECIM+1)·CLK_DIV CLK cycles per stored sample.
- RD_DATA is valid 1 cycle after RD_ADDR.
- Reads are allowed in any state.

## Test plan
- Reset: assert RST asynchronously mid-cycle → all outputs are at reset values immediately. After release, ADC_nOE=0 and ADC_CLK toggles 1,1,0,0 with CLK_DIV=4.
- Immediate capture: DEPTH=16, DECIM=0, ADC_D ramps +1 per ADC_CLK starting at 0x10 → DONE after 16 s_valid. RD_ADDR 0..15 return 0x10..0x1F consecutively, with 1-cycle latency.
- Rising trigger: TRIG_LEVEL=0x80, ADC_D steps 0x70,0x7F,0x80,0x81… → address 0 holds 0x80 and address 1 holds 0x81. A constant 0x90 input never triggers: BUSY stays high, DONE stays 0.
- Falling vs rising: mode 10 with a rising ramp through 0x80 → no trigger. A subsequent descent 0x81→0x7F → address 0 holds 0x7F.
- Decimation: DECIM=2, immediate mode, ramp from 0 → buffer holds 0,3,6,9,…; DONE after 3·DEPTH−2 s_valid.
- Re-arm: ARM pulsed midway through CAPTURE at wr_addr=5 → the state returns to WAIT_TRIG and DONE stays 0. The next trigger writes from address 0. ARM coincident with the final write → DONE does not assert.
